injector_pulse_gen: RTL
=======================

INJECTOR_PULSE_GEN -- requirements
Module: injector_pulse_gen

Interface
REQ-001 Parameter WIDTH_W, default 16: bit width of the pulse-width and timeout counters.
REQ-002 Parameter PER_W, default 8: bit width of the hold-period length.
REQ-003 Port i_clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port i_trigger, input, 1: one-cycle injection start request.
REQ-006 Port i_width, input, WIDTH_W: injection length in clock cycles; latched on an accepted trigger.
REQ-007 Port i_period_len, input, PER_W: hold-phase period in cycles; latched on an accepted trigger.
REQ-008 Port i_peak_timeout, input, WIDTH_W: maximum cycles allowed to reach peak current; 0 disables the check; latched on an accepted trigger.
REQ-009 Port i_peak, input, 1: peak-current detect from the comparator path, synchronous to i_clk.
REQ-010 Port i_fault_clr, input, 1: one-cycle request to clear a latched fault.
REQ-011 Port o_enable, output, 1: injector enable fed to the downstream peak-and-hold FSM.
REQ-012 Port o_period, output, 1: one-cycle period-start strobe fed to the downstream FSM.
REQ-013 Port o_busy, output, 1: high whenever the block is not in IDLE.
REQ-014 Port o_done, output, 1: one-cycle strobe on normal completion.
REQ-015 Port o_fault, output, 1: sticky peak-timeout fault flag.

Function
REQ-016 The block SHALL implement states IDLE, ACTIVE and FAULT.
REQ-017 All outputs SHALL be registered.
REQ-018 IDLE→ACTIVE: i_trigger high in cycle k with i_width≠0; o_enable is then high for exactly cycles k+1 through k+W, where W is the latched width.
REQ-019 A trigger with i_width=0 SHALL be ignored: no enable, no done, no fault.
REQ-020 i_trigger SHALL be ignored in ACTIVE and FAULT: no retrigger and no extension.
REQ-021 o_period SHALL pulse in cycle k+1 and every P cycles after it while o_enable is high; P=0 SHALL be treated as 1.
REQ-022 o_period SHALL never be high while o_enable is low.
REQ-023 Peak timeout: the timeout counter counts o_enable cycles until i_peak is first seen high; once i_peak is seen, the check is disarmed for the rest of the pulse.
REQ-024 If the count reaches T≠0 with no peak seen, the block SHALL go ACTIVE→FAULT: o_enable and o_period low from the next cycle, o_fault set, o_done not pulsed.
REQ-025 If i_peak is high in the same cycle the timeout is reached, peak SHALL win and no fault is raised.
REQ-026 If width expiry and timeout fall in the same cycle, normal completion SHALL win: o_done pulses and no fault is raised.
REQ-027 ACTIVE→IDLE at width expiry: o_done SHALL be high in cycle k+W+1, the first cycle o_enable is low.
REQ-028 FAULT→IDLE SHALL occur only on i_fault_clr; o_fault is low from the next cycle, and a trigger in the same cycle is ignored.
REQ-029 i_fault_clr outside FAULT SHALL have no effect.
REQ-030 Counters SHALL saturate and never wrap; W=2^WIDTH_W−1 SHALL be fully supported.

Reset
REQ-031 While i_rst_n is low, state SHALL be IDLE, all counters 0, and o_enable, o_period, o_busy, o_done and o_fault all 0, independent of i_clk.
REQ-032 Reset mid-pulse or in FAULT SHALL drop o_enable immediately, clear the fault, and not pulse o_done.
REQ-033 After i_rst_n deasserts, the first trigger SHALL be accepted no earlier than the first rising edge.

Structure
REQ-034 Package injector_pkg SHALL hold the state enum (IDLE, ACTIVE, FAULT) and the default WIDTH_W/PER_W constants, shared with the peak-and-hold FSM.
REQ-035 One sub-module, period_strobe_gen, SHALL implement the PER_W down-counter with load/enable inputs, producing o_period.

Verification
REQ-036 Trigger W=5, P=2, T=0: enable high cycles k+1..k+5, period strobes at k+1, k+3, k+5, done at k+6.
REQ-037 Trigger W=20, T=4, i_peak held low: enable low from k+5, o_fault=1, no done; i_fault_clr then returns to IDLE and a new trigger is accepted.
REQ-038 W=4, T=4, i_peak rising in the timeout cycle: no fault, done at k+5.
REQ-039 Retrigger at k+2 during W=6, plus a trigger with i_width=0 while IDLE: the pulse still ends at k+6 and the zero-width trigger produces no activity.
REQ-040 i_rst_n asserted at k+3 of W=10, then released and retriggered with W=3: enable low immediately with no done, then a clean 3-cycle pulse.

Source files
------------

// File: rtl/injector_pkg.sv
// Shared definitions for the injector pulse generator and the downstream
// peak-and-hold FSM.
//   inj_state_t  : controller state encoding (IDLE, ACTIVE, FAULT)
//   WIDTH_W_DEF  : default width of the pulse-width / peak-timeout counters
//   PER_W_DEF    : default width of the hold-period length
package injector_pkg;

    localparam int WIDTH_W_DEF = 16;
    localparam int PER_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FAULT  = 2'd2
    } inj_state_t;

endpackage

// File: rtl/period_strobe_gen.sv
// Hold-period strobe generator. Emits a one-cycle strobe on load and then
// every P cycles while run stays high; P = 0 is treated as 1.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : start of a pulse; latches i_period_len, strobes next cycle
//   i_run          : pulse continues into the next cycle
//   i_period_len   : hold period length in cycles
//   o_period       : registered period-start strobe
module period_strobe_gen #(
    parameter int PER_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [PER_W-1:0] i_period_len,
    output logic             o_period
);

    localparam logic [PER_W-1:0] P_ONE = {{(PER_W-1){1'b0}}, 1'b1};

    logic [PER_W-1:0] len_m1;
    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] load_m1;

    // A zero period behaves as one, so reload value bottoms out at 0.
    assign load_m1 = (i_period_len == '0) ? '0 : (i_period_len - P_ONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_m1   <= '0;
            cnt      <= '0;
            o_period <= 1'b0;
        end else if (i_load) begin
            len_m1   <= load_m1;
            cnt      <= load_m1;
            o_period <= 1'b1;
        end else if (i_run) begin
            if (cnt == '0) begin
                cnt      <= len_m1;
                o_period <= 1'b1;
            end else begin
                cnt      <= cnt - P_ONE;
                o_period <= 1'b0;
            end
        end else begin
            cnt      <= '0;
            o_period <= 1'b0;
        end
    end

endmodule

// File: rtl/injector_pulse_gen.sv
// Injector pulse generator: turns a trigger into an enable window of the
// latched width, with hold-period strobes and a peak-current timeout check.
// Ports:
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_trigger       : start request (accepted only in IDLE with i_width != 0)
//   i_width         : enable length in cycles
//   i_period_len    : hold period in cycles (0 treated as 1)
//   i_peak_timeout  : max enable cycles to reach peak, 0 disables
//   i_peak          : peak-current detect
//   i_fault_clr     : clears a latched timeout fault
//   o_enable, o_period, o_busy, o_done, o_fault : registered status/controls
//
// state  | meaning
// IDLE   | waiting for a non-zero-width trigger
// ACTIVE | enable high, width and peak-timeout counters running
// FAULT  | peak not reached in time; enable off until fault clear
module injector_pulse_gen
    import injector_pkg::*;
#(
    parameter int WIDTH_W = WIDTH_W_DEF,
    parameter int PER_W   = PER_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_trigger,
    input  logic [WIDTH_W-1:0] i_width,
    input  logic [PER_W-1:0]   i_period_len,
    input  logic [WIDTH_W-1:0] i_peak_timeout,
    input  logic               i_peak,
    input  logic               i_fault_clr,
    output logic               o_enable,
    output logic               o_period,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_fault
);

    localparam logic [WIDTH_W-1:0] W_ONE = {{(WIDTH_W-1){1'b0}}, 1'b1};

    inj_state_t         state, state_nxt;
    logic [WIDTH_W-1:0] width_rem;
    logic [WIDTH_W-1:0] to_rem;
    logic               to_armed;

    logic accept, width_end, timeout_hit;
    logic enable_nxt, done_nxt, fault_nxt, per_load, per_run;

    assign accept    = (state == IDLE) && i_trigger && (i_width != '0);
    assign width_end = (state == ACTIVE) && (width_rem == '0);
    // Peak in the terminal cycle and width expiry both take precedence.
    assign timeout_hit = (state == ACTIVE) && to_armed && !i_peak &&
                         (to_rem == '0) && !width_end;

    always_comb begin
        state_nxt  = state;
        enable_nxt = 1'b0;
        done_nxt   = 1'b0;
        fault_nxt  = 1'b0;
        per_load   = 1'b0;
        per_run    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt  = ACTIVE;
                    enable_nxt = 1'b1;
                    per_load   = 1'b1;
                end
            end
            ACTIVE: begin
                if (width_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = FAULT;
                    fault_nxt = 1'b1;
                end else begin
                    enable_nxt = 1'b1;
                    per_run    = 1'b1;
                end
            end
            FAULT: begin
                if (i_fault_clr) begin
                    state_nxt = IDLE;
                end else begin
                    fault_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_enable  <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_fault   <= 1'b0;
            width_rem <= '0;
            to_rem    <= '0;
            to_armed  <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_enable <= enable_nxt;
            o_busy   <= (state_nxt != IDLE);
            o_done   <= done_nxt;
            o_fault  <= fault_nxt;
            if (accept) begin
                // Both counters hold "remaining cycles after this one", so
                // terminal count is 0 and a full-scale width never wraps.
                width_rem <= i_width - W_ONE;
                to_armed  <= (i_peak_timeout != '0);
                to_rem    <= (i_peak_timeout == '0) ? '0 : (i_peak_timeout - W_ONE);
            end else if (state == ACTIVE) begin
                if (width_rem != '0) begin
                    width_rem <= width_rem - W_ONE;
                end
                if (to_armed) begin
                    if (i_peak) begin
                        to_armed <= 1'b0;
                    end else if (to_rem != '0) begin
                        to_rem <= to_rem - W_ONE;
                    end
                end
            end
        end
    end

    period_strobe_gen #(
        .PER_W (PER_W)
    ) u_period (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (per_load),
        .i_run        (per_run),
        .i_period_len (i_period_len),
        .o_period     (o_period)
    );

endmodule
